// File: rtl/bip_pkg.sv
// ============================================================================
//  Module   : bip_pkg
//  Purpose  : Shared definitions for the BIP control unit: field widths,
//             opcode values, FSM state encoding and the datapath select and
//             ALU operation codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bip_pkg;

    // Field widths
    localparam int C_NBITS_D   = 16;
    localparam int C_NBITS_OPC = 5;
    localparam int C_NBITS_OPR = 11;
    localparam int C_NBITS_PC  = 11;

    // Opcodes, instr[15:11]
    localparam logic [C_NBITS_OPC-1:0] C_OPC_HLT  = 5'b00000;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_STO  = 5'b00001;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_LD   = 5'b00010;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_LDI  = 5'b00011;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_ADD  = 5'b00100;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_ADDI = 5'b00101;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_SUB  = 5'b00110;
    localparam logic [C_NBITS_OPC-1:0] C_OPC_SUBI = 5'b00111;

    // Control FSM states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Accumulator input mux
    localparam logic [1:0] C_SELA_DMEM = 2'd0;
    localparam logic [1:0] C_SELA_IMM  = 2'd1;
    localparam logic [1:0] C_SELA_ALU  = 2'd2;

    // ALU B operand mux
    localparam logic C_SELB_DMEM = 1'b0;
    localparam logic C_SELB_IMM  = 1'b1;

    // ALU operation
    localparam logic C_OP_ADD = 1'b0;
    localparam logic C_OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/bip_pc.sv
// ============================================================================
//  Module   : bip_pc
//  Purpose  : Program counter register. Increments by one when i_inc is high
//             and wraps from all-ones back to zero.
//  Ports    : i_clk   - clock, rising edge
//             i_reset - asynchronous active-high reset (PC = 0)
//             i_inc   - increment enable
//             o_pc    - current program counter
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_pc #(
    parameter int NBITS_PC = 11
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_inc,
    output logic [NBITS_PC-1:0] o_pc
);

    logic [NBITS_PC-1:0] pc_q;
    logic [NBITS_PC-1:0] pc_d;

    // Natural modulo-2^NBITS_PC arithmetic provides the wrap-around.
    always_comb begin
        pc_d = pc_q;
        if (i_inc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/bip_control.sv
// ============================================================================
//  Module   : bip_control
//  Purpose  : Multi-cycle control unit of the BIP datapath. Fetches from a
//             synchronous instruction memory, decodes, sequences data-memory
//             access and drives the accumulator write strobe, mux selects and
//             ALU op. Terminates on HLT.
//  Ports    : i_clk, i_reset (async, active-high), i_enable (low = freeze)
//             i_instr  - imem read data, valid one cycle after o_pc
//             o_pc     - imem address
//             o_addr   - dmem address (IR operand)
//             o_imm    - IR operand sign-extended
//             o_SelA / o_SelB / o_Op - datapath selects and ALU op
//             o_WrAcc / o_WrRam / o_RdRam - strobes
//             o_halt   - high once HLT executes
//             o_cycles - enabled-cycle counter (only with BIP_CYCLE_CNT_EN)
//  Config   : BIP_CYCLE_CNT_EN adds the o_cycles saturating counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_control
    import bip_pkg::*;
#(
    parameter int NBITS_D   = C_NBITS_D,
    parameter int NBITS_OPC = C_NBITS_OPC,
    parameter int NBITS_OPR = C_NBITS_OPR,
    parameter int NBITS_PC  = C_NBITS_PC
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NBITS_D-1:0]   i_instr,
    output logic [NBITS_PC-1:0]  o_pc,
    output logic [NBITS_OPR-1:0] o_addr,
    output logic [NBITS_D-1:0]   o_imm,
    output logic [1:0]           o_SelA,
    output logic                 o_SelB,
    output logic                 o_Op,
    output logic                 o_WrAcc,
    output logic                 o_WrRam,
    output logic                 o_RdRam,
    output logic                 o_halt
`ifdef BIP_CYCLE_CNT_EN
    ,
    output logic [31:0]          o_cycles
`endif
);

    state_t               state_q;
    state_t               state_d;
    state_t               w_next;
    logic [NBITS_D-1:0]   ir_q;
    logic [NBITS_D-1:0]   ir_d;
    logic                 w_pc_inc;
    logic [NBITS_OPC-1:0] w_opcode;
    logic [NBITS_OPR-1:0] w_operand;
    logic [1:0]           w_sel_a;
    logic                 w_sel_b;
    logic                 w_op;
    logic                 w_wr_acc;
    logic                 w_wr_ram;
    logic                 w_rd_ram;
    logic                 w_halt;

    assign w_opcode  = ir_q[NBITS_D-1 -: NBITS_OPC];
    assign w_operand = ir_q[NBITS_OPR-1:0];

    bip_pc #(
        .NBITS_PC (NBITS_PC)
    ) u_pc (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_pc_inc),
        .o_pc    (o_pc)
    );

    // ------------------------------------------------------------------------
    // Next-state and output decode. w_next is the unconditional successor;
    // it only takes effect when enabled, so a frozen state re-executes its
    // outputs exactly once after release.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        w_next   = state_q;
        w_pc_inc = 1'b0;
        w_sel_a  = C_SELA_DMEM;
        w_sel_b  = C_SELB_DMEM;
        w_op     = C_OP_ADD;
        w_wr_acc = 1'b0;
        w_wr_ram = 1'b0;
        w_rd_ram = 1'b0;
        w_halt   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                w_next = ST_DECODE;
            end
            ST_DECODE: begin
                // imem data for the address presented in FETCH is valid now.
                w_next   = ST_EXEC;
                w_pc_inc = i_enable;
                if (i_enable) begin
                    ir_d = i_instr;
                end
            end
            ST_EXEC: begin
                w_next = ST_FETCH;
                case (w_opcode)
                    C_OPC_HLT: begin
                        w_halt = 1'b1;
                        w_next = ST_HALT;
                    end
                    C_OPC_STO: begin
                        w_wr_ram = 1'b1;
                    end
                    C_OPC_LD, C_OPC_ADD, C_OPC_SUB: begin
                        w_rd_ram = 1'b1;
                        w_next   = ST_WB;
                    end
                    C_OPC_LDI: begin
                        w_sel_a  = C_SELA_IMM;
                        w_wr_acc = 1'b1;
                    end
                    C_OPC_ADDI: begin
                        w_sel_a  = C_SELA_ALU;
                        w_sel_b  = C_SELB_IMM;
                        w_op     = C_OP_ADD;
                        w_wr_acc = 1'b1;
                    end
                    C_OPC_SUBI: begin
                        w_sel_a  = C_SELA_ALU;
                        w_sel_b  = C_SELB_IMM;
                        w_op     = C_OP_SUB;
                        w_wr_acc = 1'b1;
                    end
                    default: begin
                        // Unassigned opcodes behave as NOP.
                    end
                endcase
            end
            ST_WB: begin
                w_next   = ST_FETCH;
                w_wr_acc = 1'b1;
                case (w_opcode)
                    C_OPC_ADD: begin
                        w_sel_a = C_SELA_ALU;
                        w_sel_b = C_SELB_DMEM;
                        w_op    = C_OP_ADD;
                    end
                    C_OPC_SUB: begin
                        w_sel_a = C_SELA_ALU;
                        w_sel_b = C_SELB_DMEM;
                        w_op    = C_OP_SUB;
                    end
                    default: begin
                        // LD: accumulator loads straight from dmem.
                        w_sel_a = C_SELA_DMEM;
                    end
                endcase
            end
            ST_HALT: begin
                w_halt = 1'b1;
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_FETCH;
            end
        endcase

        // HALT is terminal regardless of i_enable, since w_next stays HALT.
        if (i_enable) begin
            state_d = w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign o_addr  = w_operand;
    assign o_imm   = {{(NBITS_D-NBITS_OPR){w_operand[NBITS_OPR-1]}}, w_operand};
    assign o_SelA  = w_sel_a;
    assign o_SelB  = w_sel_b;
    assign o_Op    = w_op;
    // Strobes are suppressed while frozen; selects stay as decoded.
    assign o_WrAcc = w_wr_acc & i_enable;
    assign o_WrRam = w_wr_ram & i_enable;
    assign o_RdRam = w_rd_ram & i_enable;
    assign o_halt  = w_halt;

`ifdef BIP_CYCLE_CNT_EN
    logic [31:0] cycles_q;
    logic [31:0] cycles_d;

    always_comb begin
        cycles_d = cycles_q;
        if (i_enable && (state_q != ST_HALT) && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cycles_q <= '0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign o_cycles = cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bip_control.sv
// ============================================================================
//  Module   : tb_bip_control
//  Purpose  : Self-checking bench for bip_control. Expected strobe/halt
//             events are queued by the stimulus; a negedge monitor pops and
//             compares each event the DUT presents.
//  Config   : BIP_CYCLE_CNT_EN enables the o_cycles checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bip_control;

    logic        i_clk    = 1'b0;
    logic        i_reset  = 1'b1;
    logic        i_enable = 1'b1;
    logic [15:0] i_instr  = '0;
    logic [10:0] o_pc;
    logic [10:0] o_addr;
    logic [15:0] o_imm;
    logic [1:0]  o_SelA;
    logic        o_SelB;
    logic        o_Op;
    logic        o_WrAcc;
    logic        o_WrRam;
    logic        o_RdRam;
    logic        o_halt;
`ifdef BIP_CYCLE_CNT_EN
    logic [31:0] o_cycles;
`endif

    bip_control dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_instr  (i_instr),
        .o_pc     (o_pc),
        .o_addr   (o_addr),
        .o_imm    (o_imm),
        .o_SelA   (o_SelA),
        .o_SelB   (o_SelB),
        .o_Op     (o_Op),
        .o_WrAcc  (o_WrAcc),
        .o_WrRam  (o_WrRam),
        .o_RdRam  (o_RdRam),
        .o_halt   (o_halt)
`ifdef BIP_CYCLE_CNT_EN
        ,
        .o_cycles (o_cycles)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Synchronous instruction memory model
    logic [15:0] imem [0:2047];
    always @(posedge i_clk) i_instr <= imem[o_pc];

    typedef struct packed {
        logic [15:0] cyc;
        logic        h;
        logic        wa;
        logic        wr;
        logic        rd;
        logic [1:0]  sa;
        logic        sb;
        logic        op;
        logic [10:0] addr;
        logic [15:0] imm;
    } ev_t;

    ev_t  exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    logic halt_prev = 1'b0;

    // Monitor: cycle 1 is the first cycle after reset release.
    always @(negedge i_clk) begin
        ev_t act;
        ev_t e;
        if (i_reset) cyc = 0;
        else         cyc = cyc + 1;
        if (o_WrAcc || o_WrRam || o_RdRam || (o_halt && !halt_prev)) begin
            act = '{cyc: 16'(cyc), h: o_halt && !halt_prev, wa: o_WrAcc, wr: o_WrRam,
                    rd: o_RdRam, sa: o_SelA, sb: o_SelB, op: o_Op, addr: o_addr, imm: o_imm};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event actual=%h required=none (cycle %0d)", act, cyc);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors = errors + 1;
                    $display("FAIL event actual=%h required=%h (cycle %0d, expected cycle %0d)",
                             act, e, cyc, e.cyc);
                end
            end
        end
        halt_prev = i_reset ? 1'b0 : o_halt;
    end

    task automatic ex(input int c, input logic h, input logic wa, input logic wr,
                      input logic rd, input logic [1:0] sa, input logic sb,
                      input logic op, input logic [10:0] addr, input logic [15:0] imm);
        ev_t e;
        e = '{cyc: 16'(c), h: h, wa: wa, wr: wr, rd: rd, sa: sa, sb: sb, op: op,
              addr: addr, imm: imm};
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 2048; i++) imem[i] = v;
    endtask

    // Returns at P(n)+1, i.e. 1 ns into cycle n+1.
    task automatic wait_end(input int n);
        while (cyc < n) @(posedge i_clk);
        #1;
    endtask

    task automatic start();
        @(posedge i_clk);
        #1;
        i_reset  = 1'b1;
        i_enable = 1'b1;
        #1;
        chk("rst_pc", 32'(o_pc), 32'h0);
        chk("rst_outs", {o_WrAcc, o_WrRam, o_RdRam, o_halt, o_SelA, o_SelB, o_Op}, 32'h0);
        chk("rst_ir", {o_addr, o_imm}, 32'h0);
`ifdef BIP_CYCLE_CNT_EN
        chk("rst_cycles", o_cycles, 32'h0);
`endif
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    initial begin
        // 1: LDI 5, HLT
        fill(16'h0000);
        imem[0] = 16'h1805;
        imem[1] = 16'h0000;
        ex(3, 0, 1, 0, 0, 2'd1, 0, 0, 11'h005, 16'h0005);
        ex(6, 1, 0, 0, 0, 2'd0, 0, 0, 11'h000, 16'h0000);
        start();
        wait_end(10);
        chk("t1_pc_hold", 32'(o_pc), 32'h2);
        chk("t1_halt", 32'(o_halt), 32'h1);
        chk("t1_q_empty", exp_q.size(), 32'h0);

        // 2: LDI 0x7FF (-1), ADDI 3, HLT
        fill(16'h0000);
        imem[0] = 16'h1FFF;
        imem[1] = 16'h2803;
        ex(3, 0, 1, 0, 0, 2'd1, 0, 0, 11'h7FF, 16'hFFFF);
        ex(6, 0, 1, 0, 0, 2'd2, 1, 0, 11'h003, 16'h0003);
        ex(9, 1, 0, 0, 0, 2'd0, 0, 0, 11'h000, 16'h0000);
        start();
        wait_end(12);
        chk("t2_q_empty", exp_q.size(), 32'h0);

        // 3: ADD 0x010, SUB 0x005, HLT
        fill(16'h0000);
        imem[0] = 16'h2010;
        imem[1] = 16'h3005;
        ex(3,  0, 0, 0, 1, 2'd0, 0, 0, 11'h010, 16'h0010);
        ex(4,  0, 1, 0, 0, 2'd2, 0, 0, 11'h010, 16'h0010);
        ex(7,  0, 0, 0, 1, 2'd0, 0, 0, 11'h005, 16'h0005);
        ex(8,  0, 1, 0, 0, 2'd2, 0, 1, 11'h005, 16'h0005);
        ex(11, 1, 0, 0, 0, 2'd0, 0, 0, 11'h000, 16'h0000);
        start();
        wait_end(14);
        chk("t3_q_empty", exp_q.size(), 32'h0);

        // 4: STO 0x020, opcode 11111, LD 0x7F0, HLT
        fill(16'h0000);
        imem[0] = 16'h0820;
        imem[1] = 16'hF800;
        imem[2] = 16'h17F0;
        ex(3,  0, 0, 1, 0, 2'd0, 0, 0, 11'h020, 16'h0020);
        ex(9,  0, 0, 0, 1, 2'd0, 0, 0, 11'h7F0, 16'hFFF0);
        ex(10, 0, 1, 0, 0, 2'd0, 0, 0, 11'h7F0, 16'hFFF0);
        ex(13, 1, 0, 0, 0, 2'd0, 0, 0, 11'h000, 16'h0000);
        start();
        wait_end(16);
        chk("t4_q_empty", exp_q.size(), 32'h0);

        // 5: SUBI 2 frozen for cycles 3..6, HLT
        fill(16'h0000);
        imem[0] = 16'h3802;
        ex(7,  0, 1, 0, 0, 2'd2, 1, 1, 11'h002, 16'h0002);
        ex(10, 1, 0, 0, 0, 2'd0, 0, 0, 11'h000, 16'h0000);
        start();
        wait_end(2);
        i_enable = 1'b0;
        wait_end(4);
        chk("t5_frozen_sel", {o_SelA, o_SelB, o_Op}, 32'b1011);
        chk("t5_frozen_pc", 32'(o_pc), 32'h1);
        chk("t5_frozen_wracc", 32'(o_WrAcc), 32'h0);
        wait_end(6);
        i_enable = 1'b1;
        wait_end(13);
        chk("t5_q_empty", exp_q.size(), 32'h0);

        // 6: NOPs up to 0x7FE, LD 0x011 at 0x7FF, reset during its WB
        fill(16'hF800);
        imem[2047] = 16'h1011;
        ex(6144, 0, 0, 0, 1, 2'd0, 0, 0, 11'h011, 16'h0011);
        start();
        wait_end(6142);
        chk("t6_pc_top", 32'(o_pc), 32'h7FF);
        wait_end(6143);
        chk("t6_pc_wrap", 32'(o_pc), 32'h0);
        wait_end(6144);
        i_reset = 1'b1;
        #1;
        chk("t6_rst_outs", {o_WrAcc, o_WrRam, o_RdRam, o_halt, o_SelA, o_SelB, o_Op}, 32'h0);
        chk("t6_rst_pc", 32'(o_pc), 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        wait_end(5);
        chk("t6_q_empty", exp_q.size(), 32'h0);

`ifdef BIP_CYCLE_CNT_EN
        // 7: LDI 1, LD 5, HLT -> 10 counted cycles
        fill(16'h0000);
        imem[0] = 16'h1801;
        imem[1] = 16'h1005;
        ex(3,  0, 1, 0, 0, 2'd1, 0, 0, 11'h001, 16'h0001);
        ex(6,  0, 0, 0, 1, 2'd0, 0, 0, 11'h005, 16'h0005);
        ex(7,  0, 1, 0, 0, 2'd0, 0, 0, 11'h005, 16'h0005);
        ex(10, 1, 0, 0, 0, 2'd0, 0, 0, 11'h000, 16'h0000);
        start();
        wait_end(12);
        chk("t7_cycles", o_cycles, 32'd10);
        wait_end(20);
        chk("t7_cycles_frozen", o_cycles, 32'd10);
        chk("t7_q_empty", exp_q.size(), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
